// File: rtl/bmp_pixel_processor_if.sv
// Scheduler-facing pixel bus for bmp_pixel_processor: input words, mode/operand,
// end-of-file flag and the processed-word return path.
interface bmp_pixel_processor_if #(
    parameter int DATA_BUS_SIZE = 32
);
    logic [DATA_BUS_SIZE-1:0] data_to_processor;
    logic                     scheduler_2_proc_vld;
    logic [1:0]               mode;
    logic [7:0]               data_proc;
    logic                     done;
    logic [DATA_BUS_SIZE-1:0] data_from_processor;
    logic                     vld_pr;

    modport master (
        output data_to_processor, scheduler_2_proc_vld, mode, data_proc, done,
        input  data_from_processor, vld_pr
    );

    modport slave (
        input  data_to_processor, scheduler_2_proc_vld, mode, data_proc, done,
        output data_from_processor, vld_pr
    );
endinterface

// File: rtl/bmp_pixel_processor.sv
// BMP pixel stage: per-byte brightness offset or 24-bit-pixel threshold binarisation.
// Build option PIXPROC_SATURATE_EN: brightness clamps to 00..FF instead of wrapping.
//
// state   | meaning
// IDLE    | no words buffered, output shifter empty
// ACCUM   | 1-2 threshold words buffered (shifter may still be draining)
// EMIT    | shifter draining, nothing buffered
// FLUSH   | one cycle: zero-padded partial group loaded into the shifter
module bmp_pixel_processor #(
    parameter int DATA_BUS_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bmp_pixel_processor_if.slave bus
);
    localparam int W  = DATA_BUS_SIZE;
    localparam int GW = 3 * DATA_BUS_SIZE;
    localparam logic [1:0] MODE_THR = 2'b01;
    localparam logic [1:0] MODE_BRT = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT, S_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_wcnt;
    logic [1:0]      r_last_mode;
    logic [1:0]      r_scnt;
    logic [1:0]      r_fcnt;
    logic [2*W-1:0]  r_buf;
    logic [GW-1:0]   r_shift;
    logic [GW-1:0]   r_fgrp;
    logic [W-1:0]    r_data;
    logic            r_vld;

    logic            w_accept;
    logic            w_thr_acc;
    logic            w_brt_acc;
    logic            w_grp_full;
    logic            w_flush;
    logic [1:0]      w_wcnt_base;
    logic [1:0]      w_wcnt_acc;
    logic [1:0]      w_wcnt_nxt;
    logic [1:0]      w_rem;
    logic [1:0]      w_scnt_nxt;
    logic [2*W-1:0]  w_buf_acc;
    logic [GW-1:0]   w_pad;
    logic [GW-1:0]   w_shift_adv;
    logic [GW-1:0]   w_shift_nxt;
    logic [W-1:0]    w_bright;

    function automatic logic [7:0] f_gray(input logic [7:0] b, input logic [7:0] g,
                                          input logic [7:0] r);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[9:2];
    endfunction

    // Group bytes run B,G,R,B,G,R,... from the MSB end of the 96-bit group.
    function automatic logic [GW-1:0] f_thresh(input logic [GW-1:0] grp, input logic [7:0] th);
        logic [GW-1:0] res;
        logic [7:0]    gy;
        res = '0;
        for (int p = 0; p < 4; p++) begin
            gy = f_gray(grp[GW-1-24*p -: 8], grp[GW-9-24*p -: 8], grp[GW-17-24*p -: 8]);
            res[GW-1-24*p -: 24] = (gy >= th) ? 24'hFF_FFFF : 24'h00_0000;
        end
        return res;
    endfunction

    function automatic logic [W-1:0] f_bright(input logic [W-1:0] word, input logic [7:0] off);
        logic [W-1:0] res;
`ifdef PIXPROC_SATURATE_EN
        logic [9:0]   sum;
`endif
        res = '0;
        for (int k = 0; k < W/8; k++) begin
`ifdef PIXPROC_SATURATE_EN
            sum = {2'b00, word[W-1-8*k -: 8]} + {{2{off[7]}}, off};
            if (sum[9])
                res[W-1-8*k -: 8] = 8'h00;
            else if (sum[8])
                res[W-1-8*k -: 8] = 8'hFF;
            else
                res[W-1-8*k -: 8] = sum[7:0];
`else
            res[W-1-8*k -: 8] = word[W-1-8*k -: 8] + off;
`endif
        end
        return res;
    endfunction

    always_comb begin
        w_accept    = bus.scheduler_2_proc_vld &&
                      (bus.mode == MODE_THR || bus.mode == MODE_BRT);
        w_thr_acc   = w_accept && (bus.mode == MODE_THR);
        w_brt_acc   = w_accept && (bus.mode == MODE_BRT);
        w_wcnt_base = (w_accept && bus.mode != r_last_mode) ? 2'd0 : r_wcnt;
        w_grp_full  = w_thr_acc && (w_wcnt_base == 2'd2);
        w_buf_acc   = r_buf;
        w_wcnt_acc  = w_wcnt_base;
        if (w_thr_acc) begin
            if (w_grp_full) begin
                w_wcnt_acc = 2'd0;
            end else begin
                w_wcnt_acc = w_wcnt_base + 2'd1;
                if (w_wcnt_base == 2'd0)
                    w_buf_acc[2*W-1 -: W] = bus.data_to_processor;
                else
                    w_buf_acc[W-1:0] = bus.data_to_processor;
            end
        end
        w_flush    = bus.done && (w_wcnt_acc != 2'd0);
        w_wcnt_nxt = w_flush ? 2'd0 : w_wcnt_acc;
        w_pad      = (w_wcnt_acc == 2'd1) ? {w_buf_acc[2*W-1 -: W], {(2*W){1'b0}}}
                                          : {w_buf_acc, {W{1'b0}}};
    end

    // A brightness word is queued behind whatever the shifter still holds.
    always_comb begin
        w_bright    = f_bright(bus.data_to_processor, bus.data_proc);
        w_rem       = (r_scnt == 2'd0) ? 2'd0 : r_scnt - 2'd1;
        w_shift_adv = (r_scnt == 2'd0) ? r_shift : (r_shift << W);
        w_shift_nxt = w_shift_adv;
        w_scnt_nxt  = w_rem;
        if (r_state == S_FLUSH) begin
            w_shift_nxt = f_thresh(r_fgrp, bus.data_proc);
            w_scnt_nxt  = r_fcnt;
        end else if (w_grp_full) begin
            w_shift_nxt = f_thresh({r_buf, bus.data_to_processor}, bus.data_proc);
            w_scnt_nxt  = 2'd3;
        end else if (w_brt_acc) begin
            case (w_rem)
                2'd0:    w_shift_nxt[GW-1 -: W]   = w_bright;
                2'd1:    w_shift_nxt[GW-1-W -: W] = w_bright;
                default: w_shift_nxt[W-1:0]       = w_bright;
            endcase
            w_scnt_nxt = w_rem + 2'd1;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_flush)
            w_state_nxt = S_FLUSH;
        else if (w_wcnt_nxt != 2'd0)
            w_state_nxt = S_ACCUM;
        else if (w_scnt_nxt != 2'd0)
            w_state_nxt = S_EMIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt      <= 2'd0;
            r_last_mode <= 2'b00;
            r_buf       <= '0;
            r_fgrp      <= '0;
            r_fcnt      <= 2'd0;
            r_shift     <= '0;
            r_scnt      <= 2'd0;
            r_data      <= '0;
            r_vld       <= 1'b0;
        end else begin
            r_wcnt  <= w_wcnt_nxt;
            r_buf   <= w_buf_acc;
            r_shift <= w_shift_nxt;
            r_scnt  <= w_scnt_nxt;
            r_vld   <= (r_scnt != 2'd0);
            if (w_accept)
                r_last_mode <= bus.mode;
            if (w_flush) begin
                r_fgrp <= w_pad;
                r_fcnt <= w_wcnt_acc;
            end
            if (r_scnt != 2'd0)
                r_data <= r_shift[GW-1 -: W];
        end
    end

    assign bus.data_from_processor = r_data;
    assign bus.vld_pr              = r_vld;
endmodule

// File: tb/tb_bmp_pixel_processor.sv
// Bench for bmp_pixel_processor: directed cases plus random mode segments checked
// cycle by cycle against a byte-level reference model.
module tb_bmp_pixel_processor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bmp_pixel_processor_if #(.DATA_BUS_SIZE(32)) bus();
    bmp_pixel_processor #(.DATA_BUS_SIZE(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int            n_total = 0;
    int            n_bad   = 0;
    int            cyc     = 0;
    logic [31:0]   exp_d[int];
    logic [31:0]   last_d;
    logic [31:0]   grp[$];
    logic [1:0]    m_last;
    logic [1:0]    cur_m;
    logic [7:0]    cur_dp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] m_bright(input logic [31:0] w, input logic [7:0] off);
        logic [31:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            v = int'(w[31-8*k -: 8]) + int'($signed(off));
`ifdef PIXPROC_SATURATE_EN
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
`else
            v = v & 255;
`endif
            r[31-8*k -: 8] = v[7:0];
        end
        return r;
    endfunction

    function automatic logic [95:0] m_thresh(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [7:0] th);
        logic [31:0] ws[3];
        logic [31:0] t;
        logic [7:0]  b[12];
        logic [95:0] o;
        int gray;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        for (int i = 0; i < 12; i++) begin
            t = ws[i/4] >> (24 - 8*(i%4));
            b[i] = t[7:0];
        end
        o = '0;
        for (int p = 0; p < 4; p++) begin
            gray = (int'(b[3*p]) + 2*int'(b[3*p+1]) + int'(b[3*p+2])) / 4;
            for (int j = 0; j < 3; j++)
                o[95-8*(3*p+j) -: 8] = (gray >= int'(th)) ? 8'hFF : 8'h00;
        end
        return o;
    endfunction

    task automatic model_step(input int c, input logic v, input logic [1:0] m,
                              input logic [7:0] dp, input logic dn, input logic [31:0] w);
        logic [95:0] g;
        logic [31:0] pw[3];
        int n;
        if (v && (m == 2'b01 || m == 2'b10)) begin
            if (m != m_last) grp.delete();
            m_last = m;
            if (m == 2'b10) begin
                exp_d[c+1] = m_bright(w, dp);
            end else begin
                grp.push_back(w);
                if (grp.size() == 3) begin
                    g = m_thresh(grp[0], grp[1], grp[2], dp);
                    for (int k = 0; k < 3; k++) exp_d[c+1+k] = g[95-32*k -: 32];
                    grp.delete();
                end
            end
        end
        if (dn && grp.size() > 0) begin
            n = grp.size();
            for (int i = 0; i < 3; i++) pw[i] = (i < n) ? grp[i] : 32'h0;
            g = m_thresh(pw[0], pw[1], pw[2], dp);
            for (int k = 0; k < n; k++) exp_d[c+2+k] = g[95-32*k -: 32];
            grp.delete();
        end
    endtask

    task automatic step(input logic v, input logic [1:0] m, input logic [7:0] dp,
                        input logic dn, input logic [31:0] w);
        bus.scheduler_2_proc_vld = v;
        bus.mode                 = m;
        bus.data_proc            = dp;
        bus.done                 = dn;
        bus.data_to_processor    = w;
        cur_m  = m;
        cur_dp = dp;
        @(posedge clk);
        cyc++;
        model_step(cyc, v, m, dp, dn, w);
        #1;
        if (exp_d.exists(cyc)) begin
            last_d = exp_d[cyc];
            exp_d.delete(cyc);
            check("vld_pr", {31'b0, bus.vld_pr}, 32'd1);
        end else begin
            check("vld_pr", {31'b0, bus.vld_pr}, 32'd0);
        end
        check("data", bus.data_from_processor, last_d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, cur_m, cur_dp, 1'b0, $urandom);
    endtask

    initial begin
        int nout;
        logic [1:0]  sm;
        logic [7:0]  sdp;
        int          slen;
        bus.scheduler_2_proc_vld = 1'b0;
        bus.mode = 2'b00;
        bus.data_proc = 8'h00;
        bus.done = 1'b0;
        bus.data_to_processor = 32'h0;
        cur_m = 2'b00; cur_dp = 8'h00; m_last = 2'b00; last_d = 32'h0;
        #12;
        check("rst_vld", {31'b0, bus.vld_pr}, 32'd0);
        check("rst_data", bus.data_from_processor, 32'h0);
        rst_n = 1'b1;
        idle(2);

`ifdef PIXPROC_SATURATE_EN
        step(1'b1, 2'b10, 8'h20, 1'b0, 32'hF0104080);
        idle(1);
        check("brt_sat_hi", bus.data_from_processor, 32'hFF3060A0);
        step(1'b1, 2'b10, 8'hE0, 1'b0, 32'h10F02040);
        idle(1);
        check("brt_sat_lo", bus.data_from_processor, 32'h00D00020);
`else
        step(1'b1, 2'b10, 8'h20, 1'b0, 32'hF0000000);
        idle(1);
        check("brt_wrap", bus.data_from_processor, 32'h10202020);
`endif

        // Threshold group: pixels (10,80,F0) (00,00,00) (FF,FF,FF) (40,40,40)
        step(1'b1, 2'b01, 8'h80, 1'b0, 32'h1080F000);
        step(1'b1, 2'b01, 8'h80, 1'b0, 32'h0000FFFF);
        step(1'b1, 2'b01, 8'h80, 1'b0, 32'hFF404040);
        idle(1);
        check("thr_w0", bus.data_from_processor, 32'hFFFFFF00);
        idle(1);
        check("thr_w1", bus.data_from_processor, 32'h0000FFFF);
        idle(1);
        check("thr_w2", bus.data_from_processor, 32'hFF000000);
        idle(2);

        // Flush of a two-word partial group
        step(1'b1, 2'b01, 8'h80, 1'b0, 32'hF0F0F000);
        step(1'b1, 2'b01, 8'h80, 1'b0, 32'hF0F04040);
        step(1'b0, 2'b01, 8'h80, 1'b1, 32'h0);
        nout = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (bus.vld_pr) nout++;
        end
        check("flush_cnt", nout, 32'd2);

        // Mode switch drops the partial threshold group
        step(1'b1, 2'b01, 8'h80, 1'b0, 32'hFFFFFFFF);
        step(1'b1, 2'b10, 8'h10, 1'b0, 32'h01020304);
        idle(1);
        check("mode_sw", bus.data_from_processor, 32'h11121314);
        step(1'b0, 2'b10, 8'h10, 1'b1, 32'h0);
        idle(4);

        // Reset while a group drains and two more words are buffered
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 8'h40, 1'b0, $urandom);
        rst_n = 1'b0;
        #1;
        check("rst_mid_vld", {31'b0, bus.vld_pr}, 32'd0);
        check("rst_mid_data", bus.data_from_processor, 32'h0);
        exp_d.delete();
        grp.delete();
        last_d = 32'h0;
        m_last = 2'b00;
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        rst_n = 1'b1;
        step(1'b0, 2'b01, 8'h40, 1'b1, 32'h0);
        idle(4);

        // Random segments
        for (int s = 0; s < 80; s++) begin
            sm   = 2'($urandom_range(0, 3));
            sdp  = 8'($urandom);
            slen = $urandom_range(3, 16);
            for (int i = 0; i < slen; i++)
                step(($urandom_range(0, 3) != 0), sm, sdp, 1'b0, $urandom);
            if (sm == 2'b01) begin
                idle(3);
                step(1'($urandom_range(0, 1)), sm, sdp, 1'b1, $urandom);
            end
            idle(4);
        end

        idle(4);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
